// File: rtl/display_multiplexado_if.sv
`default_nettype none
// ============================================================================
// Module   : display_multiplexado_if
// Purpose  : Bundles the message handshake and display pins of
//            display_multiplexado into one port.
// Signals  : habilita   - 1 = scan running, 0 = display dark
//            carregar   - 1-cycle strobe capturing caracteres
//            caracteres - packed 5-bit char codes, digit k at [5k+4:5k]
//            piscar     - blink request
//            pronto     - 1 = no message waiting for a frame boundary
//            seg        - {g,f,e,d,c,b,a}, active-high
//            digito     - one-hot digit enable, active-high
// Modports : master (upstream control logic), slave (the display driver)
// Revision : 1.0 - initial release
// ============================================================================
interface display_multiplexado_if #(
    parameter int NUM_DIGITOS = 4
);
    logic                       habilita;
    logic                       carregar;
    logic [5*NUM_DIGITOS-1:0]   caracteres;
    logic                       piscar;
    logic                       pronto;
    logic [6:0]                 seg;
    logic [NUM_DIGITOS-1:0]     digito;

    modport master (
        output habilita, carregar, caracteres, piscar,
        input  pronto, seg, digito
    );

    modport slave (
        input  habilita, carregar, caracteres, piscar,
        output pronto, seg, digito
    );
endinterface
`default_nettype wire

// File: rtl/display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : display_multiplexado
// Purpose  : Time-multiplexed driver for an N-digit 7-segment display.
//            Latches a packed character-code message into a shadow buffer
//            and swaps it into the active buffer only at a frame boundary,
//            so a message is never shown half old / half new.
// Ports    : clock   - system clock, rising edge
//            reset_n - asynchronous, active-low reset
//            bus     - display_multiplexado_if.slave (handshake + pins)
// Params   : NUM_DIGITOS   (1..8)  digits driven
//            DIV_VARREDURA (>=2)   clock cycles each digit stays lit
//            PISCA_QUADROS (>=1)   frames per blink half-period
// Options  : DISPLAY_PISCA_EN - when defined, piscar blinks the segments
// Revision : 1.0 - initial release
// ============================================================================
module display_multiplexado #(
    parameter int NUM_DIGITOS   = 4,
    parameter int DIV_VARREDURA = 1000,
    parameter int PISCA_QUADROS = 64
) (
    input wire                     clock,
    input wire                     reset_n,
    display_multiplexado_if.slave  bus
);

    localparam int c_PW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int c_IW = (NUM_DIGITOS > 1) ? $clog2(NUM_DIGITOS) : 1;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(DIV_VARREDURA - 1);
    localparam logic [c_IW-1:0] c_IDX_MAX = c_IW'(NUM_DIGITOS - 1);
    localparam logic [4:0]      c_BRANCO  = 5'd31;

    function automatic logic [6:0] f_fonte(input logic [4:0] codigo);
        case (codigo)
            5'd0:    return 7'h3F;
            5'd1:    return 7'h06;
            5'd2:    return 7'h5B;
            5'd3:    return 7'h4F;
            5'd4:    return 7'h66;
            5'd5:    return 7'h6D;
            5'd6:    return 7'h7D;
            5'd7:    return 7'h07;
            5'd8:    return 7'h7F;
            5'd9:    return 7'h6F;
            5'd10:   return 7'h77;  // A
            5'd11:   return 7'h7C;  // b
            5'd12:   return 7'h39;  // C
            5'd13:   return 7'h5E;  // d
            5'd14:   return 7'h79;  // E
            5'd15:   return 7'h71;  // F
            5'd16:   return 7'h50;  // r
            5'd17:   return 7'h54;  // n
            5'd18:   return 7'h5C;  // o
            5'd19:   return 7'h73;  // P
            5'd20:   return 7'h3E;  // U
            5'd21:   return 7'h38;  // L
            5'd22:   return 7'h40;  // -
            5'd23:   return 7'h76;  // H
            default: return 7'h00;  // 24..31 blank
        endcase
    endfunction

    logic [c_PW-1:0]            prescaler_q, prescaler_d;
    logic [c_IW-1:0]            indice_q,    indice_d;
    logic [NUM_DIGITOS-1:0][4:0] ativo_q,    ativo_d;
    logic [NUM_DIGITOS-1:0][4:0] sombra_q,   sombra_d;
    logic                       pendente_q,  pendente_d;
    logic [6:0]                 seg_q,       seg_d;
    logic [NUM_DIGITOS-1:0]     digito_q,    digito_d;

    logic                       w_tick;
    logic                       w_fronteira;
    logic                       w_apagado;

    assign w_tick      = bus.habilita && (prescaler_q == c_PRE_MAX);
    assign w_fronteira = w_tick && (indice_q == c_IDX_MAX);

    always_comb begin
        prescaler_d = prescaler_q;
        indice_d    = indice_q;
        ativo_d     = ativo_q;
        sombra_d    = sombra_q;
        pendente_d  = pendente_q;
        seg_d       = 7'h00;
        digito_d    = '0;

        if (bus.habilita) begin
            prescaler_d = w_tick ? '0 : prescaler_q + c_PW'(1);
        end
        if (w_tick) begin
            indice_d = (indice_q == c_IDX_MAX) ? '0 : indice_q + c_IW'(1);
        end

        // A load landing on the boundary cycle goes straight to the active
        // buffer; any older shadow content is discarded with it.
        if (bus.carregar) begin
            if (w_fronteira) begin
                ativo_d    = bus.caracteres;
                pendente_d = 1'b0;
            end else begin
                sombra_d   = bus.caracteres;
                pendente_d = 1'b1;
            end
        end else if (w_fronteira && pendente_q) begin
            ativo_d    = sombra_q;
            pendente_d = 1'b0;
        end

        if (bus.habilita) begin
            digito_d[indice_q] = 1'b1;
            seg_d = w_apagado ? 7'h00 : f_fonte(ativo_q[indice_q]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            indice_q    <= '0;
            ativo_q     <= {NUM_DIGITOS{c_BRANCO}};
            sombra_q    <= {NUM_DIGITOS{c_BRANCO}};
            pendente_q  <= 1'b0;
            seg_q       <= 7'h00;
            digito_q    <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            indice_q    <= indice_d;
            ativo_q     <= ativo_d;
            sombra_q    <= sombra_d;
            pendente_q  <= pendente_d;
            seg_q       <= seg_d;
            digito_q    <= digito_d;
        end
    end

`ifdef DISPLAY_PISCA_EN
    localparam int c_BW = $clog2(PISCA_QUADROS + 1);
    localparam logic [c_BW-1:0] c_QUADROS_MAX = c_BW'(PISCA_QUADROS - 1);

    logic [c_BW-1:0] quadros_q, quadros_d;
    logic            fase_q,    fase_d;

    always_comb begin
        quadros_d = quadros_q;
        fase_d    = fase_q;
        if (!bus.piscar) begin
            quadros_d = '0;
            fase_d    = 1'b0;
        end else if (w_fronteira) begin
            if (quadros_q == c_QUADROS_MAX) begin
                quadros_d = '0;
                fase_d    = ~fase_q;
            end else begin
                quadros_d = quadros_q + c_BW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quadros_q <= '0;
            fase_q    <= 1'b0;
        end else begin
            quadros_q <= quadros_d;
            fase_q    <= fase_d;
        end
    end

    // Gating with piscar lets the display light up the cycle after the
    // request drops, without waiting for the phase flop to clear.
    assign w_apagado = fase_q & bus.piscar;
`else
    logic unused_piscar;
    assign unused_piscar = bus.piscar;
    assign w_apagado     = 1'b0;
`endif

    assign bus.pronto = ~pendente_q;
    assign bus.seg    = seg_q;
    assign bus.digito = digito_q;

endmodule
`default_nettype wire

// File: tb/tb_display_multiplexado.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_multiplexado
// Purpose  : Self-checking bench for display_multiplexado with 4 digits,
//            4 cycles per digit and a 2-frame blink half-period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_multiplexado;

    localparam int c_ND = 4;

`ifdef DISPLAY_PISCA_EN
    localparam logic c_BLINK = 1'b1;
`else
    localparam logic c_BLINK = 1'b0;
`endif

    localparam logic [19:0] c_ERRO = {5'd18, 5'd16, 5'd16, 5'd14};
    localparam logic [19:0] c_A    = {5'd4,  5'd3,  5'd2,  5'd1};
    localparam logic [19:0] c_B    = {5'd8,  5'd7,  5'd6,  5'd5};
    localparam logic [19:0] c_C    = {5'd20, 5'd21, 5'd22, 5'd23};
    localparam logic [6:0]  c_C_SEG [4] = '{7'h76, 7'h40, 7'h38, 7'h3E};

    typedef struct {
        logic        hab;
        logic        carr;
        logic [19:0] chars;
        logic        pisc;
        logic        exp_pronto;
        logic [6:0]  exp_seg;
        logic [3:0]  exp_dig;
        int          reps;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tabela [$];

    always #5 clock = ~clock;

    display_multiplexado_if #(.NUM_DIGITOS(c_ND)) bus ();

    display_multiplexado #(
        .NUM_DIGITOS   (c_ND),
        .DIV_VARREDURA (4),
        .PISCA_QUADROS (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic vec_t mk(input logic hab, input logic carr, input logic [19:0] chars,
                                input logic pisc, input logic ep, input logic [6:0] es,
                                input logic [3:0] ed, input int reps);
        vec_t v;
        v.hab = hab; v.carr = carr; v.chars = chars; v.pisc = pisc;
        v.exp_pronto = ep; v.exp_seg = es; v.exp_dig = ed; v.reps = reps;
        return v;
    endfunction

    task automatic check(input string nm, input logic ep, input logic [6:0] es, input logic [3:0] ed);
        n_checks++;
        if (bus.pronto !== ep || bus.seg !== es || bus.digito !== ed) begin
            n_errors++;
            $display("FAIL %s: got pronto=%b seg=%h digito=%b, expected pronto=%b seg=%h digito=%b",
                     nm, bus.pronto, bus.seg, bus.digito, ep, es, ed);
        end
    endtask

    // Inputs are changed on the falling edge; outputs are checked on the
    // following falling edge, i.e. after one rising edge has consumed them.
    task automatic run_cycle(input logic hab, input logic carr, input logic [19:0] chars,
                             input logic pisc, input logic ep, input logic [6:0] es,
                             input logic [3:0] ed, input string nm);
        bus.habilita   = hab;
        bus.carregar   = carr;
        bus.caracteres = chars;
        bus.piscar     = pisc;
        @(negedge clock);
        check(nm, ep, es, ed);
    endtask

    // Cycles j0..j0+n-1 of a frame showing message C (4 cycles per digit).
    task automatic frame_cycles(input logic pisc, input logic dark, input int j0,
                                input int n, input string nm);
        for (int j = j0; j < j0 + n; j++) begin
            int         d;
            logic [6:0] es;
            d  = j / 4;
            es = dark ? 7'h00 : c_C_SEG[d];
            run_cycle(1'b1, 1'b0, '0, pisc, 1'b1, es, 4'(1 << d), $sformatf("%s_c%0d", nm, j));
        end
    endtask

    initial begin
        // Scan from reset, mid-frame load, double load + boundary load,
        // then a 10-cycle habilita pause in the middle of digit 0.
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b0001, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b0010, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b1000, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b0001, 4));
        tabela.push_back(mk(1, 1, c_ERRO, 0, 0, 7'h00, 4'b0010, 1));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h00, 4'b0010, 3));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h00, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h00, 4'b1000, 3));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h00, 4'b1000, 1));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h79, 4'b0001, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h50, 4'b0010, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h50, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h5C, 4'b1000, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h79, 4'b0001, 1));
        tabela.push_back(mk(1, 1, c_A,    0, 0, 7'h79, 4'b0001, 1));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h79, 4'b0001, 2));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h50, 4'b0010, 2));
        tabela.push_back(mk(1, 1, c_B,    0, 0, 7'h50, 4'b0010, 1));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h50, 4'b0010, 1));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h50, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 0, 7'h5C, 4'b1000, 3));
        tabela.push_back(mk(1, 1, c_C,    0, 1, 7'h5C, 4'b1000, 1));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h76, 4'b0001, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h40, 4'b0010, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h38, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h3E, 4'b1000, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h76, 4'b0001, 1));
        tabela.push_back(mk(0, 0, '0,     0, 1, 7'h00, 4'b0000, 10));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h76, 4'b0001, 3));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h40, 4'b0010, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h38, 4'b0100, 4));
        tabela.push_back(mk(1, 0, '0,     0, 1, 7'h3E, 4'b1000, 4));

        bus.habilita   = 1'b1;
        bus.carregar   = 1'b0;
        bus.caracteres = '0;
        bus.piscar     = 1'b0;

        @(negedge clock);
        check("reset_hold_0", 1'b1, 7'h00, 4'b0000);
        @(negedge clock);
        check("reset_hold_1", 1'b1, 7'h00, 4'b0000);
        reset_n = 1'b1;

        foreach (tabela[i]) begin
            for (int r = 0; r < tabela[i].reps; r++) begin
                run_cycle(tabela[i].hab, tabela[i].carr, tabela[i].chars, tabela[i].pisc,
                          tabela[i].exp_pronto, tabela[i].exp_seg, tabela[i].exp_dig,
                          $sformatf("vec%0d_r%0d", i, r));
            end
        end

        // Blink: two lit frames, two dark frames, repeating; dropping piscar
        // mid-frame relights at once and restarts the frame count.
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f0");
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f1");
        frame_cycles(1'b1, c_BLINK, 0, 16, "blink_f2");
        frame_cycles(1'b1, c_BLINK, 0, 16, "blink_f3");
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f4");
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f5");
        frame_cycles(1'b1, c_BLINK, 0,  4, "blink_f6a");
        frame_cycles(1'b0, 1'b0,    4, 12, "blink_f6b");
        frame_cycles(1'b0, 1'b0,    0, 16, "blink_f7");
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f8");
        frame_cycles(1'b1, 1'b0,    0, 16, "blink_f9");
        frame_cycles(1'b1, c_BLINK, 0, 16, "blink_f10");

        // Reset while a message is pending: outputs clear immediately and
        // the pending message never reaches the display.
        run_cycle(1'b1, 1'b1, c_A, 1'b0, 1'b0, 7'h76, 4'b0001, "load_before_reset");
        bus.carregar = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", 1'b1, 7'h00, 4'b0000);
        @(negedge clock);
        check("reset_async_hold", 1'b1, 7'h00, 4'b0000);
        reset_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 7'h00, 4'(1 << ((j / 4) % 4)),
                      $sformatf("post_reset_c%0d", j));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
